hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Consumer side of the ID/EX pipeline register. Takes the register tags that register carries into Execute (Rs1E, Rs2E, RdE) plus the Memory- and Writeback-stage destination tags.
- Drives operand forwarding selects, load-use stalls, branch flushes, and whole-pipe freeze on data-memory wait.
- Holds a small control FSM, a sticky protocol-error flag, and saturating stall/flush event counters for bring-up.
- Sits beside the 5-stage datapath; its outputs feed the IF/ID and ID/EX register enables/clears and the Execute forwarding muxes.

Parameters:
- CNT_W, 32, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Rs1D  in  5  source reg 1 of instruction in Decode.
- Rs2D  in  5  source reg 2 of instruction in Decode.
- Rs1E  in  5  source reg 1 in Execute.
- Rs2E  in  5  source reg 2 in Execute.
- RdE  in  5  destination reg in Execute.
- ResultSrcE  in  1  1 = Execute instruction is a load.
- PCSrcE  in  1  branch/jump taken, resolved in Execute.
- RdM  in  5  destination reg in Memory.
- RegWriteM  in  1  Memory instruction writes the register file.
- RdW  in  5  destination reg in Writeback.
- RegWriteW  in  1  Writeback instruction writes the register file.
- MemBusyM  in  1  data memory not ready this cycle.
- ForwardAE  out  2  ALU operand A select: 00 = RD1E, 10 = ALUResultM, 01 = ResultW.
- ForwardBE  out  2  same encoding, operand B.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- StallM  out  1  hold EX/MEM.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX (insert bubble).
- state  out  2  FSM state: 00 RUN, 01 LU_STALL, 10 MEM_WAIT.
- hz_err  out  1  sticky protocol error.
- stall_cnt  out  CNT_W  cycles with StallF high.
- flush_cnt  out  CNT_W  cycles with FlushD high.

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else ForwardAE = 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Else ForwardAE = 00.
  - Memory stage has priority over Writeback. ForwardBE is identical using Rs2E.
- Load-use detect: lwStall = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- Control outputs when MemBusyM = 0:
  - StallF = StallD = lwStall.
  - StallE = StallM = 0.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- Control outputs when MemBusyM = 1 (freeze):
  - StallF = StallD = StallE = StallM = 1.
  - FlushD = FlushE = 0. A taken branch held in Execute flushes on the first cycle after MemBusyM drops.
- Simultaneous lwStall and PCSrcE (MemBusyM = 0): StallF/StallD = 1, FlushD = 1, FlushE = 1. The flush wins on the Decode contents.
- FSM (registered; outputs above do not depend on state):
  - RUN -> MEM_WAIT if MemBusyM; RUN -> LU_STALL if lwStall && !MemBusyM; else stay in RUN.
  - LU_STALL -> MEM_WAIT if MemBusyM, else RUN. If lwStall is high again while in LU_STALL, set hz_err (the bubble in Execute makes a repeat impossible in a correct pipeline).
  - MEM_WAIT stays while MemBusyM; exits to LU_STALL if lwStall, else RUN.
- Counters:
  - stall_cnt += 1 each cycle StallF = 1.
  - flush_cnt += 1 each cycle FlushD = 1.
  - Both saturate at all-ones and never wrap.
- Reset (rst = 0, asynchronous, any cycle, including mid-stall):
  - state = RUN, hz_err = 0, stall_cnt = 0, flush_cnt = 0 immediately.
  - Combinational outputs keep following their inputs.
- hz_err is cleared only by reset.

Test Plan:
- Rs1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1 -> ForwardAE = 10. Set RegWriteM = 0 -> ForwardAE = 01. Set RdM = RdW = 0 with both RegWrite = 1 -> ForwardAE = 00.
- ResultSrcE = 1, RdE = 7, Rs2D = 7 for one cycle, then a bubble (ResultSrcE = 0) -> StallF = StallD = FlushE = 1 for exactly one cycle; state RUN -> LU_STALL -> RUN; stall_cnt = 1, hz_err = 0.
- PCSrcE = 1 for one cycle -> FlushD = FlushE = 1, StallF = 0, flush_cnt = 1.
- MemBusyM = 1 for 3 cycles with PCSrcE = 1 held -> all four stalls high, no flushes, state = MEM_WAIT for 3 cycles, stall_cnt = 3. Cycle after MemBusyM drops -> FlushD = FlushE = 1, state = RUN.
- lwStall held for 2 consecutive cycles -> hz_err = 1 and stays 1. Then pulse rst low mid-sequence -> hz_err = 0, counters = 0, state = RUN asynchronously.
- CNT_W = 4, StallF held for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Hazard control for a classic 5-stage in-order pipeline. It sits on the
// consumer side of the ID/EX register: it compares the Execute-stage source
// tags against the Memory/Writeback destination tags to steer the forwarding
// muxes. It also detects load-use hazards against the Decode-stage sources.
// From those, and from the taken-branch and data-memory-wait signals, it
// produces the stall/flush controls for the pipeline registers.
//
// The forwarding selects and stall/flush controls are purely combinational.
// The FSM state, the sticky protocol-error flag and the bring-up event
// counters are registered. None of the combinational controls depend on the
// FSM state.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   Rs1D/Rs2D   in   [4:0] Decode-stage source registers
//   Rs1E/Rs2E   in   [4:0] Execute-stage source registers
//   RdE         in   [4:0] Execute-stage destination register
//   ResultSrcE  in   Execute instruction is a load
//   PCSrcE      in   branch/jump taken (resolved in Execute)
//   RdM         in   [4:0] Memory-stage destination register
//   RegWriteM   in   Memory instruction writes the register file
//   RdW         in   [4:0] Writeback-stage destination register
//   RegWriteW   in   Writeback instruction writes the register file
//   MemBusyM    in   data memory not ready this cycle (freeze)
//   ForwardAE   out  [1:0] operand A select: 00 RD1E, 10 ALUResultM, 01 ResultW
//   ForwardBE   out  [1:0] operand B select, same encoding
//   StallF/D/E/M out hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E    out  clear IF/ID, clear ID/EX (bubble)
//   state       out  [1:0] FSM state: 00 RUN, 01 LU_STALL, 10 MEM_WAIT
//   hz_err      out  sticky protocol error (cleared only by reset)
//   stall_cnt   out  [CNT_W-1:0] saturating count of cycles with StallF
//   flush_cnt   out  [CNT_W-1:0] saturating count of cycles with FlushD
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MemBusyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       state,
    output logic             hz_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_hz_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_lw_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_stall_f;
    logic             w_stall_d;
    logic             w_stall_e;
    logic             w_stall_m;
    logic             w_flush_d;
    logic             w_flush_e;

    // Forwarding select for one operand. The Memory stage holds the younger
    // result, so it beats Writeback. x0 is never forwarded because writes to
    // it are discarded by the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding selects for the Execute-stage ALU inputs
    always_comb begin
        w_fwd_a = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        w_fwd_b = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // Load-use hazard: a load in Execute feeds an instruction in Decode
    always_comb begin
        if (ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D))) begin
            w_lw_stall = 1'b1;
        end else begin
            w_lw_stall = 1'b0;
        end
    end

    // Stall/flush controls. A memory wait freezes the whole pipe and masks
    // flushes. A taken branch held in Execute therefore flushes only on the
    // first cycle after the wait ends.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (MemBusyM) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
        end else begin
            // A load-use stall and a taken branch together: Decode is both
            // held and cleared. The clear wins, which is correct because the
            // held instruction is on the wrong path anyway.
            w_stall_f = w_lw_stall;
            w_stall_d = w_lw_stall;
            w_flush_d = PCSrcE;
            w_flush_e = w_lw_stall | PCSrcE;
        end
    end

    assign ForwardAE = w_fwd_a;
    assign ForwardBE = w_fwd_b;
    assign StallF    = w_stall_f;
    assign StallD    = w_stall_d;
    assign StallE    = w_stall_e;
    assign StallM    = w_stall_m;
    assign FlushD    = w_flush_d;
    assign FlushE    = w_flush_e;

    // Control FSM and sticky protocol-error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_hz_err <= 1'b0;
        end else begin
            // The bubble inserted by a load-use stall means the next Execute
            // instruction cannot be a load. A second load-use hit right after
            // one therefore indicates a broken pipeline.
            if ((r_state == ST_LU_STALL) && w_lw_stall) begin
                r_hz_err <= 1'b1;
            end else begin
                r_hz_err <= r_hz_err;
            end
            case (r_state)
                ST_RUN: begin
                    if (MemBusyM) begin
                        r_state <= ST_MEM_WAIT;
                    end else if (w_lw_stall) begin
                        r_state <= ST_LU_STALL;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    if (MemBusyM) begin
                        r_state <= ST_MEM_WAIT;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (MemBusyM) begin
                        r_state <= ST_MEM_WAIT;
                    end else if (w_lw_stall) begin
                        r_state <= ST_LU_STALL;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating bring-up counters; they stick at all-ones rather than wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_f && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_d && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign state     = r_state;
    assign hz_err    = r_hz_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
